fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_param.sv | 141 ++++++++++++++
 tb/tb_fifo_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: synchronous single-clock FIFO with registered read data,
// occupancy flags and sticky overflow/underflow error flags.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - asynchronous active-low reset
//   clr          - synchronous flush, overrides read/write
//   write/read   - write and read requests
//   datain       - write data (WIDTH bits)
//   dataout      - registered read data, updated by an accepted read
//   valid        - high for the cycle after an accepted read
//   empty/full/almost_empty/almost_full - occupancy flags decoded from count
//   count        - number of stored entries (0..DEPTH)
//   overflow     - sticky: write while full without a read
//   underflow    - sticky: read while empty
module fifo_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     write,
    input  logic                     read,
    input  logic [WIDTH-1:0]         datain,
    output logic [WIDTH-1:0]         dataout,
    output logic                     valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             empty_c, full_c;
    logic             wr_ok_c, rd_ok_c;

    // Occupancy flags decoded straight from the registered count
    assign empty_c      = (count_q == '0);
    assign full_c       = (count_q == CW'(DEPTH));
    assign empty        = empty_c;
    assign full         = full_c;
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));

    // Write may proceed when full only because the same-edge read frees a slot
    assign wr_ok_c = write && (!full_c || read) && !clr;
    assign rd_ok_c = read && !empty_c && !clr;

    // Next-state logic
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dataout_d   = dataout_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (write && full_c && !read) begin
                overflow_d = 1'b1;
            end
            if (read && empty_c) begin
                underflow_d = 1'b1;
            end
            if (wr_ok_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_ok_c) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                dataout_d = mem[rd_ptr_q];
                valid_d   = 1'b1;
            end
            unique case ({wr_ok_c, rd_ok_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dataout_q   <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dataout_q   <= dataout_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, intentionally not reset; the read above sees the old word
    // when a full FIFO writes and reads the same slot on one edge
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem[wr_ptr_q] <= datain;
        end
    end

    assign dataout   = dataout_q;
    assign valid     = valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed plus randomized stimulus for fifo_param, checked
// against a queue-based reference model with immediate assertions.
module tb_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             write;
    logic             read;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;
    logic             valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_dout;
    bit               m_valid;
    bit               m_ovf;
    bit               m_unf;

    fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .write        (write),
        .read         (read),
        .datain       (datain),
        .dataout      (dataout),
        .valid        (valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ":count"},     32'(count),        32'(n));
        chk({tag, ":empty"},     32'(empty),        32'(n == 0));
        chk({tag, ":full"},      32'(full),         32'(n == DEPTH));
        chk({tag, ":afull"},     32'(almost_full),  32'(n >= AF));
        chk({tag, ":aempty"},    32'(almost_empty), 32'(n <= AE));
        chk({tag, ":valid"},     32'(valid),        32'(m_valid));
        chk({tag, ":dataout"},   32'(dataout),      32'(m_dout));
        chk({tag, ":overflow"},  32'(overflow),     32'(m_ovf));
        chk({tag, ":underflow"}, 32'(underflow),    32'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Apply one cycle of requests, advance the model by the FIFO rules, check
    task automatic step(input bit w, input bit r, input bit c,
                        input logic [WIDTH-1:0] d, input string tag);
        bit f, e;
        write  = w;
        read   = r;
        clr    = c;
        datain = d;
        if (c) begin
            q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            f = (q.size() == DEPTH);
            e = (q.size() == 0);
            if (w && f && !r) m_ovf = 1'b1;
            if (r && e)       m_unf = 1'b1;
            m_valid = 1'b0;
            if (r && !e) begin
                m_dout  = q.pop_front();
                m_valid = 1'b1;
            end
            if (w && (!f || r)) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] held;
        bit w, r, c;

        rst = 1'b0; clr = 1'b0; write = 1'b0; read = 1'b0; datain = '0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fill with 0x11..0x88, then drain in order
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, WIDTH'(i * 17), "fill");
            if (i == 6) chk("afull_at_6", 32'(almost_full), 32'd1);
        end
        chk("full_after_8", 32'(full), 32'd1);

        // Overflow on lone write, then simultaneous write+read while full
        step(1'b1, 1'b0, 1'b0, 8'h99, "ovf_write");
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'hAA, "full_wr_rd");
        chk("full_wr_rd_dout", 32'(dataout), 32'h11);
        chk("full_wr_rd_cnt", 32'(count), 32'd8);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, "drain");
        end
        chk("last_is_aa", 32'(dataout), 32'hAA);
        chk("empty_after_drain", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, "idle");

        // Underflow, then read+write on empty, then read back
        step(1'b0, 1'b1, 1'b0, '0, "unf_read");
        step(1'b1, 1'b1, 1'b0, 8'h55, "empty_wr_rd");
        chk("empty_wr_rd_valid", 32'(valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, '0, "read_55");
        chk("read_55_dout", 32'(dataout), 32'h55);

        // Wrap-around with prefill of three
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom), "prefill");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, WIDTH'($urandom), "wrap");
        chk("wrap_count", 32'(count), 32'd3);

        // Clear with five entries and overflow set
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom), "refill");
        step(1'b1, 1'b0, 1'b0, 8'h77, "ovf2");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, "to_five");
        held = m_dout;
        step(1'b1, 1'b0, 1'b1, 8'hEE, "clr");
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_dout_hold", 32'(dataout), 32'(held));
        step(1'b0, 1'b1, 1'b0, '0, "clr_no_store");

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 63) == 0);
            d = WIDTH'($urandom);
            step(w, r, c, d, "rand");
        end

        // Asynchronous reset between edges during a burst
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom), "burst");
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #2;
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h3C, "post_rst_wr");
        step(1'b0, 1'b1, 1'b0, '0, "post_rst_rd");
        chk("post_rst_dout", 32'(dataout), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
